// File: rtl/sha256_pad.sv
// Single-block SHA-256 padder: collects up to 55 message bytes and emits the
// registered 512-bit padded block; longer messages are dropped with msg_err.
module sha256_pad_lane #(
  parameter int IDX = 0
) (
  input  logic [7:0] buf_byte,
  input  logic [7:0] in_data,
  input  logic       keep,
  input  logic [5:0] count,
  input  logic [6:0] n,
  output logic [7:0] pad_byte
);
  localparam logic [6:0] I = 7'(IDX);

  // The byte arriving with the last beat is not yet in the buffer.
  always_comb begin
    pad_byte = 8'h00;
    if (I < n)       pad_byte = (keep && I == {1'b0, count}) ? in_data : buf_byte;
    else if (I == n) pad_byte = 8'h80;
  end
endmodule

module sha256_pad (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [7:0]   in_data,
  input  logic         in_keep,
  input  logic         in_last,
  output logic         blk_valid,
  input  logic         blk_ready,
  output logic [511:0] blk_data,
  output logic         msg_err
);
  localparam logic [1:0] ACCUM   = 2'd0;
  localparam logic [1:0] DISCARD = 2'd1;
  localparam logic [1:0] EMIT    = 2'd2;

  logic [1:0]        state_q;
  logic [5:0]        count_q;
  logic [54:0][7:0]  buf_q;
  logic [55:0][7:0]  buf_x;
  logic [63:0][7:0]  pad;
  logic [511:0]      blk_q;
  logic              rdy_q, err_q, acc;
  logic [6:0]        n;

  assign acc       = in_valid && rdy_q;
  assign n         = 7'(count_q) + 7'(in_keep);
  assign buf_x     = {8'h00, buf_q};
  assign in_ready  = rdy_q;
  assign blk_valid = (state_q == EMIT);
  assign blk_data  = blk_q;
  assign msg_err   = err_q;

  // Byte i lands at pad[63-i] so byte 0 sits in the top of blk_data.
  genvar gi;
  generate
    for (gi = 0; gi < 56; gi++) begin : g_lane
      sha256_pad_lane #(.IDX(gi)) u_lane (
        .buf_byte (buf_x[gi]),
        .in_data  (in_data),
        .keep     (in_keep),
        .count    (count_q),
        .n        (n),
        .pad_byte (pad[63-gi])
      );
    end
  endgenerate
  assign pad[7:0] = {54'b0, n, 3'b0};

  // Stale bytes past count never reach the output, so no reset is needed.
  always_ff @(posedge clk) begin
    if (state_q == ACCUM && acc && in_keep && count_q != 6'd55)
      buf_q[count_q] <= in_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ACCUM;
      count_q <= 6'd0;
      blk_q   <= '0;
      rdy_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      err_q <= 1'b0;
      rdy_q <= 1'b1;
      case (state_q)
        ACCUM: if (acc) begin
          if (in_keep && count_q == 6'd55) begin
            count_q <= 6'd0;
            if (in_last) err_q   <= 1'b1;
            else         state_q <= DISCARD;
          end else begin
            if (in_keep) count_q <= count_q + 6'd1;
            if (in_last) begin
              blk_q   <= pad;
              state_q <= EMIT;
              rdy_q   <= 1'b0;
              count_q <= 6'd0;
            end
          end
        end
        DISCARD: if (acc && in_last) begin
          state_q <= ACCUM;
          err_q   <= 1'b1;
        end
        EMIT: begin
          if (blk_ready) state_q <= ACCUM;
          else           rdy_q   <= 1'b0;
        end
        default: state_q <= ACCUM;
      endcase
    end
  end
endmodule
